// File: rtl/store_queue_pkg.sv
// Shared types and constants for the store queue and its age-ordered match search.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents: entry record sq_entry_t, store microop encodings, pointer width.
package store_queue_pkg;

  localparam int SQ_DEPTH      = 4;
  localparam int SQ_ADDR_BITS  = 32;
  localparam int SQ_DATA_WIDTH = 32;
  localparam int SQ_MICROOP    = 5;
  localparam int SQ_ROB_TICKET = 3;

  localparam int PTR_W = $clog2(SQ_DEPTH);

  localparam logic [SQ_MICROOP-1:0] UOP_SW = 5'b00110;
  localparam logic [SQ_MICROOP-1:0] UOP_SH = 5'b00111;
  localparam logic [SQ_MICROOP-1:0] UOP_SB = 5'b01000;

  typedef struct packed {
    logic                     vld;
    logic                     committed;
    logic [SQ_ADDR_BITS-1:0]  addr;
    logic [SQ_DATA_WIDTH-1:0] data;
    logic [SQ_MICROOP-1:0]    microop;
    logic [SQ_ROB_TICKET-1:0] ticket;
  } sq_entry_t;

  // Only a full-word store can supply a complete forwarded word.
  function automatic logic is_word_store(input logic [SQ_MICROOP-1:0] uop);
    return uop == UOP_SW;
  endfunction

endpackage

// File: rtl/store_queue_sq_age_match.sv
// Youngest-match priority search over N candidates ordered oldest (0) to youngest (N-1).
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports: cand_vld/cand_addr/cand_full per candidate, query_addr in;
//        hit, index (age position of youngest match), is_full_word out.
module sq_age_match
  import store_queue_pkg::*;
#(
  parameter int N  = SQ_DEPTH + 1,
  parameter int AW = SQ_ADDR_BITS - 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]         cand_vld,
  input  logic [N-1:0][AW-1:0] cand_addr,
  input  logic [N-1:0]         cand_full,
  input  logic [AW-1:0]        query_addr,
  output logic                 hit,
  output logic [IW-1:0]        index,
  output logic                 is_full_word
);

  // Later (younger) candidates override earlier ones, so the last match wins.
  always_comb begin
    hit          = 1'b0;
    index        = '0;
    is_full_word = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (cand_vld[k] && (cand_addr[k] == query_addr)) begin
        hit          = 1'b1;
        index        = IW'(k);
        is_full_word = cand_full[k];
      end
    end
  end

endmodule

// File: rtl/store_queue.sv
// Store queue: holds executed stores until ROB commit, drains committed stores in order
// to the cache, and answers the LSU store-to-load forwarding query every cycle.
// Latency: push visible as entry next cycle (same-cycle bypass for forwarding); commit in N
//          gives cache_writeback_valid at N+1 when the entry is head; forwarding is combinational.
// Backpressure: pushes while full are dropped and set sticky overflow_err; the drain holds the
//          head until cache_wb_ready.
//
// Ports: clk/rst (sync, active-high); store_* push; frw_* forwarding query/result;
//        commit_valid/commit_ticket; flush; cache_writeback_valid/cache_wb_*/cache_wb_ready;
//        sq_full, sq_empty, overflow_err status.
// Option: define STORE_QUEUE_FORWARD_EN to forward full-word hits; otherwise any word match stalls.
// Entry storage is sized by store_queue_pkg; parameters must match the package values.
module store_queue
  import store_queue_pkg::*;
#(
  parameter int DEPTH      = SQ_DEPTH,
  parameter int ADDR_BITS  = SQ_ADDR_BITS,
  parameter int DATA_WIDTH = SQ_DATA_WIDTH,
  parameter int MICROOP    = SQ_MICROOP,
  parameter int ROB_TICKET = SQ_ROB_TICKET
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  store_valid,
  input  logic [ADDR_BITS-1:0]  store_address,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [MICROOP-1:0]    store_microop,
  input  logic [ROB_TICKET-1:0] store_ticket,
  input  logic [ADDR_BITS-1:0]  frw_address,
  input  logic [MICROOP-1:0]    frw_microop,
  output logic [DATA_WIDTH-1:0] frw_data,
  output logic                  frw_valid,
  output logic                  frw_stall,
  input  logic                  commit_valid,
  input  logic [ROB_TICKET-1:0] commit_ticket,
  input  logic                  flush,
  output logic                  cache_writeback_valid,
  output logic [ADDR_BITS-1:0]  cache_wb_addr,
  output logic [DATA_WIDTH-1:0] cache_wb_data,
  output logic [MICROOP-1:0]    cache_wb_microop,
  input  logic                  cache_wb_ready,
  output logic                  sq_full,
  output logic                  sq_empty,
  output logic                  overflow_err
);

  localparam int CW = PTR_W + 1;
  localparam int IW = $clog2(DEPTH + 1);
  localparam int AW = ADDR_BITS - 2;

  sq_entry_t        entries_q [DEPTH];
  sq_entry_t        entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;

  sq_entry_t        head_entry;
  logic             drain_fire;
  logic             head_hole;
  logic             pop;
  logic             push_fire;
  logic [CW-1:0]    young_cnt;

  assign head_entry = entries_q[head_q];
  assign sq_full    = (count_q == CW'(DEPTH));
  assign sq_empty   = (count_q == '0);
  assign overflow_err = overflow_q;

  assign cache_writeback_valid = head_entry.vld & head_entry.committed;
  assign cache_wb_addr    = cache_writeback_valid ? head_entry.addr    : '0;
  assign cache_wb_data    = cache_writeback_valid ? head_entry.data    : '0;
  assign cache_wb_microop = cache_writeback_valid ? head_entry.microop : '0;

  assign drain_fire = cache_writeback_valid & cache_wb_ready;
  // An out-of-order commit followed by a flush can leave an invalidated slot in front of a
  // kept committed entry; the head steps over such a hole so the drain cannot deadlock.
  assign head_hole  = !sq_empty && !head_entry.vld;
  assign pop        = drain_fire | head_hole;
  assign push_fire  = store_valid & !sq_full & !flush;

  always_comb begin
    entries_d  = entries_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q | (store_valid & sq_full);
    young_cnt  = '0;

    // Commit first so a same-cycle flush sees the newly committed entry.
    for (int i = 0; i < DEPTH; i++) begin
      if (commit_valid && entries_q[i].vld && !entries_q[i].committed &&
          (entries_q[i].ticket == commit_ticket)) begin
        entries_d[i].committed = 1'b1;
      end
    end

    if (pop) begin
      entries_d[head_q].vld = 1'b0;
      head_d = head_q + PTR_W'(1);
    end

    if (flush) begin
      // Number of slots from head up to and including the youngest surviving committed entry.
      for (int k = 0; k < DEPTH; k++) begin
        if (entries_q[PTR_W'(head_q + PTR_W'(k))].vld &&
            entries_d[PTR_W'(head_q + PTR_W'(k))].committed) begin
          young_cnt = CW'(k + 1);
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (!entries_d[i].committed) entries_d[i].vld = 1'b0;
      end
      if (young_cnt == '0) begin
        head_d  = head_q;
        tail_d  = head_q;
        count_d = '0;
      end else begin
        // young_cnt == DEPTH wraps the tail back onto head, which is the full case.
        tail_d  = head_q + PTR_W'(young_cnt);
        count_d = young_cnt - CW'(pop);
      end
    end else begin
      if (push_fire) begin
        entries_d[tail_q].vld       = 1'b1;
        entries_d[tail_q].committed = 1'b0;
        entries_d[tail_q].addr      = store_address;
        entries_d[tail_q].data      = store_data;
        entries_d[tail_q].microop   = store_microop;
        entries_d[tail_q].ticket    = store_ticket;
        tail_d = tail_q + PTR_W'(1);
      end
      count_d = count_q + CW'(push_fire) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Forwarding candidates in age order from head; the incoming push is the youngest.
  logic [DEPTH:0]         cand_vld;
  logic [DEPTH:0][AW-1:0] cand_addr;
  logic [DEPTH:0]         cand_full;
  logic                   m_hit;
  logic [IW-1:0]          m_idx;
  logic                   m_full;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      cand_vld[k]  = entries_q[PTR_W'(head_q + PTR_W'(k))].vld;
      cand_addr[k] = entries_q[PTR_W'(head_q + PTR_W'(k))].addr[ADDR_BITS-1:2];
      cand_full[k] = is_word_store(entries_q[PTR_W'(head_q + PTR_W'(k))].microop);
    end
    cand_vld[DEPTH]  = store_valid;
    cand_addr[DEPTH] = store_address[ADDR_BITS-1:2];
    cand_full[DEPTH] = is_word_store(store_microop);
  end

  sq_age_match #(
    .N  (DEPTH + 1),
    .AW (AW)
  ) u_age_match (
    .cand_vld     (cand_vld),
    .cand_addr    (cand_addr),
    .cand_full    (cand_full),
    .query_addr   (frw_address[ADDR_BITS-1:2]),
    .hit          (m_hit),
    .index        (m_idx),
    .is_full_word (m_full)
  );

`ifdef STORE_QUEUE_FORWARD_EN
  logic [DATA_WIDTH-1:0] hit_data;

  always_comb begin
    if (m_idx == IW'(DEPTH)) hit_data = store_data;
    else                     hit_data = entries_q[PTR_W'(head_q + PTR_W'(m_idx))].data;
  end

  assign frw_valid = m_hit & m_full;
  assign frw_stall = m_hit & !m_full;
  assign frw_data  = frw_valid ? hit_data : '0;

  logic unused_fwd;
  assign unused_fwd = ^{frw_microop, frw_address[1:0]};
`else
  // Without forwarding, any overlap with an older store makes the load wait for the drain.
  assign frw_valid = 1'b0;
  assign frw_stall = m_hit;
  assign frw_data  = '0;

  logic unused_fwd;
  assign unused_fwd = ^{frw_microop, frw_address[1:0], m_idx, m_full};
`endif

endmodule
